// File: rtl/game_pkg.sv
// Shared move-code definitions for the game core and its input front end.
package game_pkg;

  typedef logic [2:0] move_t;

  localparam move_t MV_NONE = 3'd0;
  localparam move_t MV_W    = 3'd1;
  localparam move_t MV_S    = 3'd2;
  localparam move_t MV_UP   = 3'd3;
  localparam move_t MV_DOWN = 3'd4;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  // Codes above MV_DOWN are not moves and read as idle.
  function automatic move_t sanitize(input logic [2:0] raw);
    return (raw > MV_DOWN) ? MV_NONE : raw;
  endfunction

endpackage

// File: rtl/move_repeater.sv
// Per-player press/auto-repeat detector: turns a level move code into one-cycle
// request pulses (press, then first repeat after HOLD_DELAY, then every REPEAT_PERIOD).
module move_repeater
  import game_pkg::*;
#(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [2:0] move,
  output logic       req,
  output logic [2:0] req_code
);

  localparam int MAX_PERIOD = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW         = $clog2(MAX_PERIOD);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REPEAT_LD = CW'(REPEAT_PERIOD - 1);

  move_t         code;
  move_t         prev_code;
  logic [CW-1:0] cnt;
  logic          synced;
  logic          armed;
  logic          press;
  logic          repeat_hit;

  assign code = sanitize(move);

  // synced blocks the first edge after reset so a key held through reset is not a press;
  // armed blocks repeats of a key that was already down when game_en rose.
  assign press      = synced && game_en && (code != MV_NONE) && (code != prev_code);
  assign repeat_hit = synced && game_en && armed && (code != MV_NONE) &&
                      (code == prev_code) && (cnt == '0);

  assign req      = press || repeat_hit;
  assign req_code = code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_code <= MV_NONE;
      cnt       <= '0;
      synced    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      prev_code <= code;
      synced    <= 1'b1;
      if (!game_en || !synced || code == MV_NONE) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (press) begin
        cnt   <= HOLD_LD;
        armed <= 1'b1;
      end else if (repeat_hit) begin
        cnt <= REPEAT_LD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_arbiter.sv
// Round-robin arbiter sharing the game core's move port between two players,
// with one pending request per player (latest wins) and a stable valid/ready offer.
module move_arbiter
  import game_pkg::*;
#(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [2:0] p1_move,
  input  logic [2:0] p2_move,
  output logic       mv_valid,
  output logic       mv_player,
  output logic [2:0] mv_code,
  input  logic       mv_ready
);

  logic [1:0] req;
  move_t      req_code [2];
  logic [1:0] pend;
  move_t      pend_code [2];
  logic       last_grant;
  logic       slot_free;
  logic       do_load;
  logic       gsel;

  move_repeater #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rep_p1 (
    .clk     (clk),
    .rst     (rst),
    .game_en (game_en),
    .move    (p1_move),
    .req     (req[0]),
    .req_code(req_code[0])
  );

  move_repeater #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rep_p2 (
    .clk     (clk),
    .rst     (rst),
    .game_en (game_en),
    .move    (p2_move),
    .req     (req[1]),
    .req_code(req_code[1])
  );

  always_comb begin
    slot_free = !mv_valid || mv_ready;
    do_load   = game_en && slot_free && (pend != 2'b00);
    if (pend == 2'b11)
      gsel = ~last_grant;
    else if (pend[0])
      gsel = PLAYER1;
    else
      gsel = PLAYER2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_valid   <= 1'b0;
      mv_player  <= PLAYER1;
      mv_code    <= MV_NONE;
      last_grant <= PLAYER2;
    end else if (do_load) begin
      mv_valid   <= 1'b1;
      mv_player  <= gsel;
      mv_code    <= pend_code[gsel];
      last_grant <= gsel;
    end else if (mv_ready) begin
      mv_valid <= 1'b0;
    end
  end

  // A fresh request on the grant edge beats the grant, so the new code stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= 2'b00;
      pend_code[0] <= MV_NONE;
      pend_code[1] <= MV_NONE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!game_en) begin
          pend[i] <= 1'b0;
        end else if (req[i]) begin
          pend[i]      <= 1'b1;
          pend_code[i] <= req_code[i];
        end else if (do_load && gsel == i[0]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule
